bcd_display_scanner: RTL and testbench

- Downstream consumer of the synchronous decade/BCD up-counter chain.
- Captures a 4-digit packed BCD value from the counter stage on a load strobe into a shadow register, so the display never tears mid-count.
- Time-multiplexes the captured value onto a common-anode 4-digit seven-segment display: one digit enabled per dwell period, registered segment and anode outputs.
- Also provides leading-zero blanking and invalid-BCD flagging.

---
 rtl/bcd_display_scanner_if.sv | 19 +
 rtl/bcd_display_scanner.sv | 91 +++++++++
 tb/tb_bcd_display_scanner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_scanner_if.sv
// rtl/bcd_display_scanner_if.sv - capture/display signal bundle for the BCD display scanner
interface bcd_display_scanner_if;
  logic        load;
  logic [15:0] bcd_in;
  logic        lzb_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        bcd_err;

  modport master (
    output load, bcd_in, lzb_en,
    input  seg, an, bcd_err
  );

  modport slave (
    input  load, bcd_in, lzb_en,
    output seg, an, bcd_err
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - snapshot 4-digit BCD and scan it onto a common-anode 7-seg display
module bcd_display_scanner #(
  parameter  int DWELL = 4,
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic                 clk,
  input  logic                 clr_n,
  bcd_display_scanner_if.slave bus
);

  logic [CNT_W-1:0] r_div_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_shadow;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_bcd_err;

  logic             w_wrap;
  logic [1:0]       w_idx_nxt;
  logic [15:0]      w_shadow_nxt;
  logic [3:0]       w_digit;
  logic [3:1]       w_lz;
  logic             w_blank;
  logic             w_err;
  logic [6:0]       w_seg_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  assign w_wrap       = (r_div_cnt == CNT_W'(DWELL - 1));
  assign w_idx_nxt    = w_wrap ? r_idx + 2'd1 : r_idx;
  assign w_shadow_nxt = bus.load ? bus.bcd_in : r_shadow;
  assign w_digit      = w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4];

  // w_lz[k]: digits 3..k of the next shadow are all zero
  assign w_lz[3] = (w_shadow_nxt[15:12] == 4'd0);
  assign w_lz[2] = w_lz[3] && (w_shadow_nxt[11:8] == 4'd0);
  assign w_lz[1] = w_lz[2] && (w_shadow_nxt[7:4] == 4'd0);

  assign w_err = (w_shadow_nxt[15:12] > 4'd9) || (w_shadow_nxt[11:8] > 4'd9) ||
                 (w_shadow_nxt[7:4]   > 4'd9) || (w_shadow_nxt[3:0]  > 4'd9);

  always_comb begin
    w_blank = 1'b0;
    case (w_idx_nxt)
      2'd1:    w_blank = w_lz[1];
      2'd2:    w_blank = w_lz[2];
      2'd3:    w_blank = w_lz[3];
      default: w_blank = 1'b0;
    endcase
    w_blank   = w_blank && bus.lzb_en;
    w_seg_nxt = w_blank ? 7'h00 : decode(w_digit);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_div_cnt <= '0;
      r_idx     <= 2'd0;
      r_shadow  <= 16'h0000;
      r_an      <= 4'b1111;
      r_seg     <= 7'h00;
      r_bcd_err <= 1'b0;
    end else begin
      r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
      r_idx     <= w_idx_nxt;
      r_shadow  <= w_shadow_nxt;
      // Anode and segments come from the same idx_nxt so they always switch together
      r_an      <= ~(4'b0001 << w_idx_nxt);
      r_seg     <= w_seg_nxt;
      r_bcd_err <= w_err;
    end
  end

  assign bus.an      = r_an;
  assign bus.seg     = r_seg;
  assign bus.bcd_err = r_bcd_err;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - directed self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic clr_n;

  bcd_display_scanner_if bus();

  bcd_display_scanner #(.DWELL(DWELL)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int m_div;
  int m_idx;

  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  logic [6:0] tab [4];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_div == DWELL - 1) begin
      m_div = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_div++;
    end
    @(negedge clk);
  endtask

  task automatic chk_scan(input string tag);
    logic [3:0] ea;
    ea = ~(4'b0001 << m_idx);
    chk({tag, "_an"}, {12'h0, bus.an}, {12'h0, ea});
    chk({tag, "_seg"}, {9'h0, bus.seg}, {9'h0, tab[m_idx]});
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_scan(tag);
    end
  endtask

  task automatic load_val(input logic [15:0] v);
    bus.load   = 1'b1;
    bus.bcd_in = v;
    tick();
    bus.load   = 1'b0;
  endtask

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (c) begin
        if (r[k*4 +: 4] == 4'd9) r[k*4 +: 4] = 4'd0;
        else begin
          r[k*4 +: 4] = r[k*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [15:0] ctr;
  logic [15:0] snap;
  int          guard;

  initial begin
    clr_n      = 1'b0;
    bus.load   = 1'b0;
    bus.bcd_in = 16'h0000;
    bus.lzb_en = 1'b0;
    m_div      = 0;
    m_idx      = 0;

    // reset held for two cycles
    @(negedge clk);
    chk("rst_an", {12'h0, bus.an}, 16'h000F);
    chk("rst_seg", {9'h0, bus.seg}, 16'h0000);
    @(negedge clk);
    chk("rst_err", {15'h0, bus.bcd_err}, 16'h0000);
    chk("rst_an2", {12'h0, bus.an}, 16'h000F);
    clr_n = 1'b1;

    // first scan: shadow=0000, lzb off
    tab = '{7'h3F, 7'h3F, 7'h3F, 7'h3F};
    tick();
    chk("first_an", {12'h0, bus.an}, 16'h000E);
    chk("first_seg", {9'h0, bus.seg}, 16'h003F);
    run("scan0", 16);

    // decode and scan order
    tab = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    load_val(16'h1234);
    chk_scan("ld1234");
    run("dec1234", 16);

    // leading-zero blanking
    bus.lzb_en = 1'b1;
    tab = '{7'h3F, 7'h6F, 7'h00, 7'h00};
    load_val(16'h0090);
    chk_scan("ld0090");
    run("lzb0090", 16);
    tab = '{7'h3F, 7'h00, 7'h00, 7'h00};
    load_val(16'h0000);
    chk_scan("ld0000");
    run("lzb0000", 16);
    bus.lzb_en = 1'b0;
    tab = '{7'h3F, 7'h3F, 7'h3F, 7'h3F};
    run("nolzb0000", 16);

    // invalid BCD flagging
    tab = '{7'h66, 7'h40, 7'h5B, 7'h06};
    load_val(16'h12A4);
    chk("err_set", {15'h0, bus.bcd_err}, 16'h0001);
    chk_scan("ld12A4");
    run("inv12A4", 16);
    chk("err_hold", {15'h0, bus.bcd_err}, 16'h0001);
    tab = '{7'h6F, 7'h6F, 7'h3F, 7'h3F};
    load_val(16'h0099);
    chk("err_clr", {15'h0, bus.bcd_err}, 16'h0000);
    run("dec0099", 8);

    // invalid nibble is never blanked
    bus.lzb_en = 1'b1;
    tab = '{7'h3F, 7'h3F, 7'h40, 7'h00};
    load_val(16'h0A00);
    chk("err_0A00", {15'h0, bus.bcd_err}, 16'h0001);
    run("lzb0A00", 16);
    bus.lzb_en = 1'b0;

    // snapshot: running counter, load every 40 cycles
    ctr  = 16'h0995;
    snap = 16'h0A00;
    for (int c = 0; c < 120; c++) begin
      bus.bcd_in = ctr;
      bus.load   = (c % 40 == 0);
      tick();
      if (bus.load) snap = ctr;
      bus.load = 1'b0;
      ctr = bcd_inc(ctr);
      for (int k = 0; k < 4; k++) tab[k] = lut[snap[k*4 +: 4]];
      chk_scan("snap");
    end

    // asynchronous reset mid-scan at idx=2, div_cnt=1
    load_val(16'h88F8);
    chk("err_88F8", {15'h0, bus.bcd_err}, 16'h0001);
    guard = 0;
    while (!(m_idx == 2 && m_div == 1) && guard < 40) begin
      tick();
      guard++;
    end
    chk("align", {15'h0, (m_idx == 2 && m_div == 1)}, 16'h0001);
    chk("pre_rst_an", {12'h0, bus.an}, 16'h000B);
    #2 clr_n = 1'b0;
    #1;
    chk("async_an", {12'h0, bus.an}, 16'h000F);
    chk("async_seg", {9'h0, bus.seg}, 16'h0000);
    chk("async_err", {15'h0, bus.bcd_err}, 16'h0000);
    @(posedge clk);
    #1;
    chk("held_an", {12'h0, bus.an}, 16'h000F);
    @(negedge clk);
    clr_n = 1'b1;
    m_div = 0;
    m_idx = 0;
    tab = '{7'h3F, 7'h3F, 7'h3F, 7'h3F};
    tick();
    chk("post_an", {12'h0, bus.an}, 16'h000E);
    chk("post_seg", {9'h0, bus.seg}, 16'h003F);
    chk("post_err", {15'h0, bus.bcd_err}, 16'h0000);
    run("post", 8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
